mac_row_driver: RTL and testbench
=================================

MAC_ROW_DRIVER -- requirements
Module: mac_row_driver

Interface
REQ-001 Parameter bw, default 2: lane width of each west data output.
REQ-002 Parameter col, default 4: number of MAC columns in the driven row.
REQ-003 Port clk, input, 1: single clock, rising-edge active.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: begins a load/execute job; sampled only in IDLE.
REQ-006 Port mode, input, 1: job precision; 0 = 2-bit, 1 = 4-bit; sampled with start.
REQ-007 Port wt_data, input, 2*bw: weight word.
REQ-008 Port wt_valid, input, 1: wt_data is valid.
REQ-009 Port wt_ready, output, 1: weight word can be accepted.
REQ-010 Port act_data, input, 2*bw: activation word.
REQ-011 Port act_valid, input, 1: act_data is valid.
REQ-012 Port act_last, input, 1: this activation is the final one of the job.
REQ-013 Port act_ready, output, 1: activation word can be accepted.
REQ-014 Port inst_w, output, 3: row instruction {mode, exec, load}.
REQ-015 Port in_w0, output, bw: low lane, equal to data[bw-1:0].
REQ-016 Port in_w1, output, bw: high lane, equal to data[2*bw-1:bw].
REQ-017 Port busy, output, 1: high in every state except IDLE.
REQ-018 Port done, output, 1: one-cycle job-complete pulse.

Function
REQ-019 States: IDLE, LOAD, EXEC, DRAIN, DONE; state encoding is free.
REQ-020 IDLE with start=1: latch mode into job_mode, clear counters, go to LOAD.
REQ-021 Weight count per job (W): 2*col when job_mode=0; col when job_mode=1.
REQ-022 wt_ready is 1 only in LOAD while weight count < W.
REQ-023 act_ready is 1 only in EXEC.
REQ-024 Outputs inst_w, in_w0 and in_w1 are registered, with one cycle latency from the accepting edge.
REQ-025 Accepted weight: next cycle inst_w={job_mode,0,1} and lanes={wt_data}.
REQ-026 Accepted activation: next cycle inst_w={job_mode,1,0} and lanes={act_data}.
REQ-027 Any cycle without an accepted word is a bubble: inst_w={job_mode,0,0}, lanes 0.
REQ-028 The W-th weight is accepted: go to EXEC on the same edge.
REQ-029 No activation is accepted in the cycle the W-th weight is accepted.
REQ-030 Activation accepted with act_last=1: go to DRAIN on the same edge.
REQ-031 DRAIN lasts exactly col cycles of bubbles, counted by a wrap-free counter, then goes to DONE.
REQ-032 DONE lasts one cycle: done=1, then return to IDLE.
REQ-033 start outside IDLE is ignored.
REQ-034 mode changes after the start cycle do not affect job_mode.
REQ-035 act_valid=1 outside EXEC is ignored and consumes nothing.
REQ-036 Bubbles never advance the weight count or the activation count.
REQ-037 The activation count is 16 bits, saturating at 16'hFFFF, and is not an output.
REQ-038 With wt_valid held high and no stalls, LOAD takes exactly W cycles.

Reset
REQ-039 reset=0 immediately forces, without waiting for a clock: state IDLE; inst_w=3'b000; in_w0=0; in_w1=0; wt_ready=0; act_ready=0; busy=0; done=0; all counters 0.
REQ-040 Reset asserted mid-job discards the job; after release, no partial job resumes.
REQ-041 After reset releases, the first start is honoured on the next rising edge.

Verification
REQ-042 2-bit load: mode=0, start, then 8 back-to-back weights 4'h1,2,3,4,8,0,9,7.
- Required: inst_w=3'b001 for 8 consecutive cycles, lanes matching each word in order.
- Required: the FSM then enters EXEC.
REQ-043 4-bit job: mode=1, weights 4'h1,E,7,8, then activations 0..15 with act_last on 15.
- Required: 4 load cycles, then 16 cycles of inst_w=3'b110 with {in_w1,in_w0}=0..15.
- Required: then 4 bubble cycles, then done=1 for exactly one cycle.
REQ-044 Stalls: wt_valid low for 3 cycles partway through the load.
- Required: 3 bubble cycles of inst_w={mode,0,0}, and the weight count is unchanged.
- Required: the total LOAD duration is W+3 cycles.
REQ-045 Ignored inputs: start pulsed in EXEC, and mode toggled mid-job.
- Required: no state change, and inst_w[2] stays at the latched mode.
REQ-046 Reset mid-job: reset=0 for 1 cycle during EXEC.
- Required: all outputs are 0 asynchronously and the state is IDLE.
- Required: after release, a fresh 4-bit job completes normally.

Source files
------------

// File: rtl/mac_row_driver.sv
// rtl/mac_row_driver.sv - feeds one MAC row with weight loads, activation execs and drain bubbles
//
// Purpose:
//   Runs one load/execute job per start pulse. Weights are streamed in first
//   (2*col words for a 2-bit job, col words for a 4-bit job), then
//   activations until the one flagged act_last. After that the row is flushed
//   with col bubble cycles, and done pulses for one cycle.
//   Every cycle drives one registered instruction {mode, exec, load} and two
//   lanes onto the row. A cycle with no accepted word is a bubble.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      begins a job; only looked at in IDLE
//   mode       job precision (0 = 2-bit, 1 = 4-bit); captured with start
//   wt_data    weight word;      wt_valid / wt_ready handshake
//   act_data   activation word;  act_valid / act_ready handshake, act_last ends the job
//   inst_w     registered row instruction {mode, exec, load}
//   in_w0      registered low lane  (word[bw-1:0])
//   in_w1      registered high lane (word[2*bw-1:bw])
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle job-complete pulse

module mac_row_driver #(
  parameter int bw  = 2,
  parameter int col = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  input  logic [2*bw-1:0] wt_data,
  input  logic            wt_valid,
  output logic            wt_ready,
  input  logic [2*bw-1:0] act_data,
  input  logic            act_valid,
  input  logic            act_last,
  output logic            act_ready,
  output logic [2:0]      inst_w,
  output logic [bw-1:0]   in_w0,
  output logic [bw-1:0]   in_w1,
  output logic            busy,
  output logic            done
);

  // Weight counter must hold the largest weight count (2*col) without wrapping.
  localparam int WCW = $clog2(2 * col + 1);
  // Drain counter counts 0..col-1.
  localparam int DCW = $clog2(col + 1);

  localparam logic [WCW-1:0] WT_LIMIT_2B = WCW'(2 * col);
  localparam logic [WCW-1:0] WT_LIMIT_4B = WCW'(col);
  localparam logic [DCW-1:0] DRAIN_LAST  = DCW'(col - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      state_q,     state_d;
  logic            job_mode_q,  job_mode_d;
  logic [WCW-1:0]  wt_cnt_q,    wt_cnt_d;
  logic [15:0]     act_cnt_q,   act_cnt_d;
  logic [DCW-1:0]  drain_cnt_q, drain_cnt_d;
  logic [2:0]      inst_q,      inst_d;
  logic [2*bw-1:0] lane_q,      lane_d;

  logic [WCW-1:0]  wt_limit;
  logic [WCW-1:0]  wt_cnt_inc;
  logic            wt_acc;
  logic            act_acc;

  // Handshake side: ready signals are pure decodes of the current state so
  // an asynchronous reset drops them immediately along with the state.
  assign wt_limit   = job_mode_q ? WT_LIMIT_4B : WT_LIMIT_2B;
  assign wt_cnt_inc = wt_cnt_q + 1'b1;

  assign wt_ready  = (state_q == S_LOAD) && (wt_cnt_q < wt_limit);
  assign act_ready = (state_q == S_EXEC);

  assign wt_acc  = wt_valid  & wt_ready;
  assign act_acc = act_valid & act_ready;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  assign inst_w = inst_q;
  assign in_w0  = lane_q[bw-1:0];
  assign in_w1  = lane_q[2*bw-1:bw];

  always_comb begin
    state_d     = state_q;
    job_mode_d  = job_mode_q;
    wt_cnt_d    = wt_cnt_q;
    act_cnt_d   = act_cnt_q;
    drain_cnt_d = drain_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          job_mode_d  = mode;
          wt_cnt_d    = '0;
          act_cnt_d   = '0;
          drain_cnt_d = '0;
          state_d     = S_LOAD;
        end
      end

      S_LOAD: begin
        if (wt_acc) begin
          wt_cnt_d = wt_cnt_inc;
          // Leaving on the accepting edge of the last weight keeps act_ready
          // low in that cycle, so no activation can overlap the final load.
          if (wt_cnt_inc == wt_limit) begin
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        if (act_acc) begin
          if (act_cnt_q != 16'hFFFF) begin
            act_cnt_d = act_cnt_q + 16'd1;
          end
          if (act_last) begin
            drain_cnt_d = '0;
            state_d     = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // One bubble per column so the last activation ripples out of the row.
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Row instruction for the next cycle. Using job_mode_d means the bubble
  // issued on the start edge already carries the new job's precision.
  // wt_acc and act_acc are exclusive because their ready signals decode
  // different states.
  always_comb begin
    inst_d = {job_mode_d, act_acc, wt_acc};
    lane_d = '0;
    if (wt_acc) begin
      lane_d = wt_data;
    end else if (act_acc) begin
      lane_d = act_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      job_mode_q  <= 1'b0;
      wt_cnt_q    <= '0;
      act_cnt_q   <= '0;
      drain_cnt_q <= '0;
      inst_q      <= 3'b000;
      lane_q      <= '0;
    end else begin
      state_q     <= state_d;
      job_mode_q  <= job_mode_d;
      wt_cnt_q    <= wt_cnt_d;
      act_cnt_q   <= act_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      inst_q      <= inst_d;
      lane_q      <= lane_d;
    end
  end

endmodule

// File: tb/tb_mac_row_driver.sv
// tb/tb_mac_row_driver.sv - self-checking bench for mac_row_driver

module tb_mac_row_driver;

  localparam int BW  = 2;
  localparam int COL = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            mode;
  logic [2*BW-1:0] wt_data;
  logic            wt_valid;
  logic            wt_ready;
  logic [2*BW-1:0] act_data;
  logic            act_valid;
  logic            act_last;
  logic            act_ready;
  logic [2:0]      inst_w;
  logic [BW-1:0]   in_w0;
  logic [BW-1:0]   in_w1;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  mac_row_driver #(.bw(BW), .col(COL)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .wt_data   (wt_data),
    .wt_valid  (wt_valid),
    .wt_ready  (wt_ready),
    .act_data  (act_data),
    .act_valid (act_valid),
    .act_last  (act_last),
    .act_ready (act_ready),
    .inst_w    (inst_w),
    .in_w0     (in_w0),
    .in_w1     (in_w1),
    .busy      (busy),
    .done      (done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: job phase 0 idle, 1 load, 2 exec, 3 drain, 4 done.
  int              m_phase;
  int              m_wcnt;
  int              m_dleft;
  logic            m_mj;
  logic [2:0]      e_inst;
  logic [2*BW-1:0] e_lane;

  typedef struct {
    logic [3:0] data;
    logic [2:0] exp_inst;
    logic [3:0] exp_lane;
  } vec_t;

  vec_t load2 [8];
  vec_t load4 [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int wlim(input logic md);
    return md ? COL : 2 * COL;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_wcnt  = 0;
    m_dleft = 0;
    m_mj    = 1'b0;
    e_inst  = 3'b000;
    e_lane  = '0;
  endtask

  task automatic model_step();
    logic acc_w, acc_a;
    acc_w = (m_phase == 1) && wt_valid;
    acc_a = (m_phase == 2) && act_valid;
    case (m_phase)
      0: if (start) begin m_mj = mode; m_wcnt = 0; m_phase = 1; end
      1: if (acc_w) begin
           m_wcnt++;
           if (m_wcnt == wlim(m_mj)) m_phase = 2;
         end
      2: if (acc_a && act_last) begin m_phase = 3; m_dleft = COL; end
      3: begin m_dleft--; if (m_dleft == 0) m_phase = 4; end
      default: m_phase = 0;
    endcase
    if (acc_w) begin
      e_inst = {m_mj, 2'b01}; e_lane = wt_data;
    end else if (acc_a) begin
      e_inst = {m_mj, 2'b10}; e_lane = act_data;
    end else begin
      e_inst = {m_mj, 2'b00}; e_lane = '0;
    end
  endtask

  task automatic check_outputs();
    chk("inst_w",    32'(inst_w),          32'(e_inst));
    chk("lanes",     32'({in_w1, in_w0}),  32'(e_lane));
    chk("wt_ready",  32'(wt_ready),        32'(m_phase == 1));
    chk("act_ready", 32'(act_ready),       32'(m_phase == 2));
    chk("busy",      32'(busy),            32'(m_phase != 0));
    chk("done",      32'(done),            32'(m_phase == 4));
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    start = 1'b0; wt_valid = 1'b0; act_valid = 1'b0; act_last = 1'b0;
    wt_data = '0; act_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_inst"},  32'(inst_w),    32'd0);
    chk({tag, "_w0"},    32'(in_w0),     32'd0);
    chk({tag, "_w1"},    32'(in_w1),     32'd0);
    chk({tag, "_wrdy"},  32'(wt_ready),  32'd0);
    chk({tag, "_ardy"},  32'(act_ready), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (m_phase != 0 && n < bound) begin
      cycle();
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic start_job(input logic md);
    mode = md; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic finish_with_one_act(input string tag);
    act_valid = 1'b1; act_data = 4'h5; act_last = 1'b1;
    cycle();
    idle_inputs();
    wait_idle(tag, 50);
  endtask

  task automatic run_job(input logic md, input int nacts, input int stall_pct);
    int ai = 0;
    int guard = 0;
    start_job(md);
    while (m_phase != 0 && guard < 3000) begin
      wt_valid  = ($urandom_range(0, 99) >= stall_pct);
      wt_data   = (2*BW)'($urandom);
      act_valid = (ai < nacts) && ($urandom_range(0, 99) >= stall_pct);
      act_data  = (2*BW)'($urandom);
      act_last  = (ai == nacts - 1);
      start     = ($urandom_range(0, 9) == 0);
      mode      = 1'($urandom_range(0, 1));
      if (m_phase == 2 && act_valid) ai++;
      cycle();
      guard++;
    end
    idle_inputs();
    chk("job_timeout_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [3:0] w2 [8];
    logic [3:0] w4 [4];
    int load_cycles;
    int n;

    w2 = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h0, 4'h9, 4'h7};
    w4 = '{4'h1, 4'hE, 4'h7, 4'h8};
    for (int i = 0; i < 8; i++) load2[i] = '{w2[i], 3'b001, w2[i]};
    for (int i = 0; i < 4; i++) load4[i] = '{w4[i], 3'b101, w4[i]};

    // Reset state, checked before any clock edge.
    reset = 1'b0; mode = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 2-bit load; start right after reset release, mode toggled afterwards.
    start_job(1'b0);
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wt_valid = 1'b1; wt_data = load2[i].data;
      cycle();
      chk("t042_inst", 32'(inst_w),         32'(load2[i].exp_inst));
      chk("t042_lane", 32'({in_w1, in_w0}), 32'(load2[i].exp_lane));
    end
    wt_valid = 1'b0;
    chk("t042_exec", 32'(act_ready), 32'd1);
    finish_with_one_act("t042");

    // 4-bit job: 4 weights, 16 activations, drain, done.
    start_job(1'b1);
    for (int i = 0; i < 4; i++) begin
      wt_valid = 1'b1; wt_data = load4[i].data;
      cycle();
      chk("t043_wt_inst", 32'(inst_w),         32'(load4[i].exp_inst));
      chk("t043_wt_lane", 32'({in_w1, in_w0}), 32'(load4[i].exp_lane));
    end
    wt_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      act_valid = 1'b1; act_data = 4'(i); act_last = (i == 15);
      cycle();
      chk("t043_act_inst", 32'(inst_w),         32'd6);
      chk("t043_act_lane", 32'({in_w1, in_w0}), 32'(i));
    end
    idle_inputs();
    n = 0;
    while (!done && n < 10) begin
      cycle();
      n++;
    end
    chk("t043_drain_len", 32'(n), 32'(COL));
    cycle();
    chk("t043_done_once", 32'(done), 32'd0);

    // Stalls: 3 idle cycles in the middle of a 2-bit load.
    start_job(1'b0);
    load_cycles = 0;
    for (int k = 0; k < 11; k++) begin
      if (wt_ready) load_cycles++;
      if (k >= 3 && k <= 5) begin
        wt_valid = 1'b0;
      end else begin
        wt_valid = 1'b1; wt_data = 4'(k + 3);
      end
      cycle();
      if (k >= 3 && k <= 5) begin
        chk("t044_bubble_inst", 32'(inst_w),         32'd0);
        chk("t044_bubble_lane", 32'({in_w1, in_w0}), 32'd0);
      end
    end
    wt_valid = 1'b0;
    chk("t044_load_len", 32'(load_cycles), 32'd11);
    chk("t044_exec", 32'(act_ready), 32'd1);
    finish_with_one_act("t044");

    // Ignored inputs: act_valid during load, start and mode toggling in exec.
    start_job(1'b1);
    act_valid = 1'b1; act_data = 4'hF; act_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wt_valid = 1'b1; wt_data = 4'(i + 9);
      cycle();
    end
    wt_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      act_valid = 1'b1; act_data = 4'(i + 2); act_last = (i == 5);
      start = (i == 2); mode = i[0];
      cycle();
      chk("t045_mode_bit", 32'(inst_w[2]), 32'd1);
      chk("t045_busy",     32'(busy),      32'd1);
    end
    idle_inputs();
    wait_idle("t045", 50);

    // Reset in the middle of EXEC, then a fresh 4-bit job.
    start_job(1'b1);
    for (int i = 0; i < 4; i++) begin
      wt_valid = 1'b1; wt_data = 4'(i + 1);
      cycle();
    end
    wt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      act_valid = 1'b1; act_data = 4'(i + 12); act_last = 1'b0;
      cycle();
    end
    reset = 1'b0;
    #1;
    check_all_zero("t046_async");
    model_reset();
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
    idle_inputs();
    cycle();
    run_job(1'b1, 16, 0);

    // Randomized jobs with stalls and noise on ignored inputs.
    for (int j = 0; j < 12; j++) begin
      run_job(1'($urandom_range(0, 1)), $urandom_range(1, 20), $urandom_range(0, 50));
      repeat ($urandom_range(0, 2)) cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
